// File: rtl/k_sync2_w2r_rempty.sv
// Read-domain half of a dual-clock FIFO: write-pointer synchronizer, read pointer and empty flag.
// Define K_W2R_RLEVEL_EN to add the rlevel fill-level output.
module k_sync2_w2r_rempty #(
  parameter int unsigned addr_size = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rinc,
  input  logic [addr_size:0]   wptr,
  output logic [addr_size:0]   rq2_wptr,
  output logic [addr_size:0]   rptr,
  output logic [addr_size-1:0] raddr,
  output logic                 rempty,
  output logic                 rundf
`ifdef K_W2R_RLEVEL_EN
  ,
  output logic [addr_size:0]   rlevel
`endif
);

  logic [addr_size:0] rq1_wptr_q;
  logic [addr_size:0] rbin_q;
  logic               rpop;
  logic [addr_size:0] rbinnext;
  logic [addr_size:0] rgraynext;
  logic               rempty_d;
  logic               rundf_d;

  always_comb begin
    rpop      = rinc & ~rempty;
    rbinnext  = rbin_q + {{addr_size{1'b0}}, rpop};
    rgraynext = (rbinnext >> 1) ^ rbinnext;
    // Compare all addr_size+1 bits so a full FIFO never reads as empty
    rempty_d  = (rgraynext == rq2_wptr);
    rundf_d   = rundf | (rinc & rempty);
  end

  // Plain two-flop synchronizer; nothing may sit between the stages
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq1_wptr_q <= '0;
      rq2_wptr   <= '0;
    end else begin
      rq1_wptr_q <= wptr;
      rq2_wptr   <= rq1_wptr_q;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
      rundf  <= 1'b0;
    end else begin
      rbin_q <= rbinnext;
      rptr   <= rgraynext;
      rempty <= rempty_d;
      rundf  <= rundf_d;
    end
  end

  assign raddr = rbin_q[addr_size-1:0];

`ifdef K_W2R_RLEVEL_EN
  logic [addr_size:0] wbin_s;

  always_comb begin
    wbin_s            = '0;
    wbin_s[addr_size] = rq2_wptr[addr_size];
    for (int i = int'(addr_size) - 1; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
    end
  end

  // Lags the writer by the synchronizer delay, so it never over-reports
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rlevel <= '0;
    end else begin
      rlevel <= wbin_s - rbinnext;
    end
  end
`endif

endmodule

// File: tb/tb_k_sync2_w2r_rempty.sv
// Self-checking bench for k_sync2_w2r_rempty: directed vector table, wrap sequence,
// and randomized traffic compared against a count-based reference model.
module tb_k_sync2_w2r_rempty;
  localparam int unsigned AW   = 4;
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned PMOD = 1 << PW;
  localparam int unsigned DEP  = 1 << AW;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rinc;
  logic [AW:0]   wptr;
  logic [AW:0]   rq2_wptr;
  logic [AW:0]   rptr;
  logic [AW-1:0] raddr;
  logic          rempty;
  logic          rundf;
`ifdef K_W2R_RLEVEL_EN
  logic [AW:0]   rlevel;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: Gray write pointer pipeline plus read count
  logic [AW:0] m_q1, m_q2;
  int unsigned m_rd;
  bit          m_empty, m_undf;
  int unsigned m_level;
  logic [AW:0] prev_rptr;

  typedef struct {
    bit          rst;
    bit          inc;
    logic [AW:0] wp;
    bit          e_empty;
    logic [AW:0] e_rptr;
    logic [AW-1:0] e_raddr;
    logic [AW:0] e_rq2;
    bit          e_undf;
  } vec_t;
  vec_t tbl[14];

  always #5 rclk = ~rclk;

  k_sync2_w2r_rempty #(
    .addr_size(AW)
  ) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rinc    (rinc),
    .wptr    (wptr),
    .rq2_wptr(rq2_wptr),
    .rptr    (rptr),
    .raddr   (raddr),
    .rempty  (rempty),
    .rundf   (rundf)
`ifdef K_W2R_RLEVEL_EN
    ,
    .rlevel  (rlevel)
`endif
  );

  function automatic int unsigned g2b(input logic [AW:0] g);
    int unsigned gi;
    int unsigned b;
    gi = 32'(g);
    b  = 0;
    for (int s = 0; s < int'(PW); s++) b = b ^ (gi >> s);
    return b % PMOD;
  endfunction

  function automatic logic [AW:0] b2g(input int unsigned b);
    int unsigned m;
    int unsigned x;
    m = b % PMOD;
    x = m ^ (m >> 1);
    return x[AW:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit inc, input logic [AW:0] wp);
    bit          pop;
    int unsigned rdn;
    if (r) begin
      m_q1 = '0; m_q2 = '0; m_rd = 0; m_empty = 1'b1; m_undf = 1'b0; m_level = 0;
    end else begin
      pop = inc && !m_empty;
      rdn = (m_rd + (pop ? 1 : 0)) % PMOD;
      if (inc && m_empty) m_undf = 1'b1;
      m_level = (g2b(m_q2) + PMOD - rdn) % PMOD;
      m_empty = (rdn == g2b(m_q2));
      m_q2 = m_q1;
      m_q1 = wp;
      m_rd = rdn;
    end
  endtask

  task automatic step(input bit r, input bit inc, input logic [AW:0] wp);
    rrst = r; rinc = inc; wptr = wp;
    @(posedge rclk);
    model_update(r, inc, wp);
    #1;
    if (!r) chk("rptr_one_bit_change", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
    prev_rptr = rptr;
  endtask

  task automatic check_model();
    chk("m_rq2_wptr", 32'(rq2_wptr), 32'(m_q2));
    chk("m_rptr", 32'(rptr), 32'(b2g(m_rd)));
    chk("m_raddr", 32'(raddr), m_rd % DEP);
    chk("m_rempty", 32'(rempty), 32'(m_empty));
    chk("m_rundf", 32'(rundf), 32'(m_undf));
`ifdef K_W2R_RLEVEL_EN
    chk("m_rlevel", 32'(rlevel), m_level);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned wc;
    int          wraps;
    int          toggles;
    logic [AW-1:0] pa;
    logic        pm;

    rrst = 1'b1; rinc = 1'b0; wptr = '0; prev_rptr = '0;
    m_q1 = '0; m_q2 = '0; m_rd = 0; m_empty = 1'b1; m_undf = 1'b0; m_level = 0;

    // rst inc wptr | empty rptr raddr rq2 undf
    tbl[0]  = '{1'b1, 1'b1, 5'b00011, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 5'b00011, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'b00001, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'b00001, 1'b1, 5'b00000, 4'd0, 5'b00001, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5'b00001, 1'b0, 5'b00000, 4'd0, 5'b00001, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'b00010, 1'b0, 5'b00000, 4'd0, 5'b00001, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'b00010, 1'b0, 5'b00000, 4'd0, 5'b00010, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 5'b00010, 1'b0, 5'b00001, 4'd1, 5'b00010, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'b00010, 1'b0, 5'b00011, 4'd2, 5'b00010, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 5'b00010, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 5'b00010, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 5'b00010, 1'b1, 5'b00010, 4'd3, 5'b00010, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 5'b00010, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].inc, tbl[i].wp);
      chk($sformatf("t%0d_rempty", i), 32'(rempty), 32'(tbl[i].e_empty));
      chk($sformatf("t%0d_rptr", i), 32'(rptr), 32'(tbl[i].e_rptr));
      chk($sformatf("t%0d_raddr", i), 32'(raddr), 32'(tbl[i].e_raddr));
      chk($sformatf("t%0d_rq2_wptr", i), 32'(rq2_wptr), 32'(tbl[i].e_rq2));
      chk($sformatf("t%0d_rundf", i), 32'(rundf), 32'(tbl[i].e_undf));
    end

    // Wrap: 40 words written one per cycle, reader always requesting
    step(1'b1, 1'b0, '0);
    check_model();
    wraps = 0; toggles = 0; pa = raddr; pm = rptr[AW];
    for (int w = 1; w <= 46; w++) begin
      step(1'b0, 1'b1, b2g(w > 40 ? 40 : w));
      check_model();
      if (pa == 4'd15 && raddr == 4'd0) wraps++;
      if (rptr[AW] != pm) toggles++;
      pa = raddr; pm = rptr[AW];
    end
    chk("wrap_raddr_wraps", 32'(wraps), 32'd2);
    chk("wrap_rptr_msb_toggles", 32'(toggles), 32'd2);
    chk("wrap_final_rptr", 32'(rptr), 32'(5'b01100));
    chk("wrap_final_raddr", 32'(raddr), 32'd8);
    chk("wrap_final_rempty", 32'(rempty), 32'd1);

`ifdef K_W2R_RLEVEL_EN
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, b2g(10));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, b2g(10));
    chk("level_after_3_pops", 32'(rlevel), 32'd7);
    for (int i = 0; i < 20 && !rempty; i++) step(1'b0, 1'b1, b2g(10));
    chk("level_drained_rempty", 32'(rempty), 32'd1);
    chk("level_drained_zero", 32'(rlevel), 32'd0);
`endif

    // Randomized traffic against the model
    step(1'b1, 1'b0, '0);
    check_model();
    wc = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r;
      bit inc;
      r = ($urandom_range(0, 299) == 0);
      if (r) begin
        wc = 0;
      end else if (((wc + PMOD - m_rd) % PMOD) < DEP && $urandom_range(0, 1) == 1) begin
        wc = (wc + 1) % PMOD;
      end
      inc = ($urandom_range(0, 99) < ((n % 1000) < 500 ? 25 : 75));
      step(r, inc, b2g(wc));
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/k_sync2_w2r_rempty.md
Name: k_sync2_w2r_rempty

Overview:
- Read-domain half of the dual-clock FIFO.
- Brings the writer's Gray-coded write pointer into the read clock domain through a 2-flop synchronizer.
- Owns the read pointer in binary and Gray, generates the RAM read address, and produces a registered empty flag.
- Pairs with the read-to-write pointer synchronizer and the write-side full logic; rptr from this block feeds that synchronizer.

Parameters:
- addr_size, 4, FIFO address width. Depth is 2^addr_size; pointers are addr_size+1 bits, with the MSB as the wrap bit.

Ports:
- rclk  input  1  read-domain clock; all state updates on its rising edge.
- rrst  input  1  synchronous active-high reset, sampled on rising rclk.
- rinc  input  1  read request; pops one word when rempty is low.
- wptr  input  addr_size+1  Gray-coded write pointer from the write domain (asynchronous to rclk).
- rq2_wptr  output  addr_size+1  write pointer after 2 rclk flops, Gray.
- rptr  output  addr_size+1  registered Gray read pointer, sent to the write domain.
- raddr  output  addr_size  RAM read address, equal to the low bits of the binary read pointer.
- rempty  output  1  registered empty flag.
- rundf  output  1  sticky underflow flag.

Behaviour:
- Reset: on a rising rclk with rrst=1, the next state is rq1_wptr=0, rq2_wptr=0, rbin=0, rptr=0, raddr=0, rempty=1, rundf=0. This holds regardless of wptr or rinc.
- Synchronizer: rq1_wptr<=wptr, rq2_wptr<=rq1_wptr. No logic between the two flops. A wptr change is visible on rq2_wptr 2 rclk edges later.
- Pop qualifier: rpop = rinc & ~rempty.
- Pointer arithmetic:
  - rbinnext = rbin + rpop, modulo 2^(addr_size+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - rbin<=rbinnext, rptr<=rgraynext.
- raddr = rbin[addr_size-1:0], driven straight from the register with no combinational path from rinc.
- Empty: rempty <= (rgraynext == rq2_wptr), registered.
  - Deasserts on the 3rd rclk edge after the first write's wptr change.
  - Asserts on the same edge that consumes the last word, so there is no extra lag on the read side.
- Read data: the RAM read at raddr is valid while rempty=0. A pop advances raddr on the next edge.
- Underflow: rinc=1 while rempty=1 leaves the pointers unchanged and sets rundf=1 on that edge. rundf stays set until rrst.
- Wrap-around:
  - After 2^addr_size pops, raddr returns to 0 and the rbin MSB toggles.
  - After 2^(addr_size+1) pops, the full pointer returns to 0.
  - Empty detection uses the full addr_size+1 bits so that "empty" and "full" are never confused.
- Simultaneous write and read: when the last word is popped on the same edge that rq2_wptr advances, rempty compares rgraynext against the new rq2_wptr value. rempty stays 0 if a new word has arrived.
- Reset mid-operation: rrst overrides rinc. rempty=1 from the following edge; the pointers and rundf clear, and any in-flight synchronizer contents are discarded.
- rptr changes by at most 1 bit per rclk edge (Gray property). The verification bench checks this.

Optional Feature:
- Macro: K_W2R_RLEVEL_EN.
- With the macro defined, an extra output rlevel [addr_size:0] is present.
  - Each cycle, rq2_wptr is converted Gray-to-binary (wbin_s) and rlevel <= (wbin_s - rbinnext) mod 2^(addr_size+1).
  - Range is 0..2^addr_size; the value is conservative, lagging the writer by 2 cycles.
  - Reset value is 0.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold rrst=1 for 2 cycles with wptr=5'b00011 and rinc=1 -> rempty=1, rptr=0, raddr=0, rq2_wptr=0, rundf=0.
- Latency: from reset, change wptr 00000->00001 at t0 with rinc=0 -> rq2_wptr=00001 after 2 edges; rempty falls on the 3rd edge.
- Drain: wptr=Gray(3)=00010, pop 3 times -> raddr steps 0,1,2,3; rempty rises on the edge of the 3rd pop; rptr=Gray(3)=00010.
- Underflow: with rempty=1, pulse rinc for 1 cycle -> rbin unchanged, rundf=1 and stays 1; a later rrst clears it.
- Wrap: with addr_size=4, write and pop 40 words in total -> raddr wraps at 16 and 32; the rptr MSB toggles at 16 and 32; rempty is never falsely 0 and no extra pops occur.
- Level (K_W2R_RLEVEL_EN): wptr=Gray(10), rbin=3 after settling -> rlevel=7. Pop with no new writes until empty -> rlevel reaches 0 in the same cycle that rempty=1.
